// File: rtl/buffer_loader.sv
// Host-side loader: packs a 16-bit host stream into weight (80b) or input (16b)
// buffer words and writes them at consecutive, wrapping addresses.
module buffer_loader (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_sel,
    input  logic [6:0]  cmd_base,
    input  logic [6:0]  cmd_len,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_data,
    input  logic        abort,
    output logic        weight_we,
    output logic [6:0]  weight_addr,
    output logic [79:0] weight_wdata,
    output logic        input_we,
    output logic [6:0]  input_addr,
    output logic [15:0] input_wdata,
    output logic        busy,
    output logic        done
);

    localparam int unsigned AW       = 7;
    localparam int unsigned DW       = 16;
    localparam int unsigned WW       = 80;
    localparam int unsigned LW       = 3;
    localparam int unsigned LANES    = 5;
    localparam int unsigned PACKED_N = LANES - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic                          sel_q, sel_d;
    logic [AW-1:0]                 base_q, base_d;
    logic [AW-1:0]                 len_q, len_d;
    logic [AW-1:0]                 widx_q, widx_d;
    logic [LW-1:0]                 lane_q, lane_d;
    logic [PACKED_N-1:0][DW-1:0]   pack_q, pack_d;

    logic          weight_we_q, weight_we_d;
    logic [AW-1:0] weight_addr_q, weight_addr_d;
    logic [WW-1:0] weight_wdata_q, weight_wdata_d;
    logic          input_we_q, input_we_d;
    logic [AW-1:0] input_addr_q, input_addr_d;
    logic [DW-1:0] input_wdata_q, input_wdata_d;

    logic cmd_fire;
    logic beat_fire;
    logic word_done;
    logic last_word;

    assign cmd_fire  = cmd_valid & cmd_ready;
    assign beat_fire = s_valid & s_ready;
    assign word_done = beat_fire & (sel_q | (lane_q == LW'(LANES - 1)));
    assign last_word = word_done & (widx_q == len_q);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_fire) state_d = LOAD;
            LOAD:    if (last_word) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
        end
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        cmd_ready = 1'b0;
        s_ready   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE:    cmd_ready = ~rst & ~abort;
            LOAD: begin
                s_ready = ~abort;
                busy    = 1'b1;
            end
            DONE:    done = ~abort;
            default: ;
        endcase
    end

    // Command latch, lane packing and write-port staging
    always_comb begin
        sel_d          = sel_q;
        base_d         = base_q;
        len_d          = len_q;
        widx_d         = widx_q;
        lane_d         = lane_q;
        pack_d         = pack_q;
        weight_we_d    = 1'b0;
        weight_addr_d  = weight_addr_q;
        weight_wdata_d = weight_wdata_q;
        input_we_d     = 1'b0;
        input_addr_d   = input_addr_q;
        input_wdata_d  = input_wdata_q;

        if (cmd_fire) begin
            sel_d  = cmd_sel;
            base_d = cmd_base;
            len_d  = cmd_len;
            widx_d = '0;
            lane_d = '0;
            pack_d = '0;
        end

        if (abort) begin
            lane_d = '0;
            pack_d = '0;
        end

        if (beat_fire) begin
            if (sel_q) begin
                input_we_d    = 1'b1;
                input_addr_d  = base_q + widx_q;
                input_wdata_d = s_data;
                widx_d        = widx_q + AW'(1);
            end else if (word_done) begin
                weight_we_d    = 1'b1;
                weight_addr_d  = base_q + widx_q;
                weight_wdata_d = {s_data, pack_q};
                lane_d         = '0;
                widx_d         = widx_q + AW'(1);
            end else begin
                pack_d[lane_q[1:0]] = s_data;
                lane_d              = lane_q + LW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q          <= 1'b0;
            base_q         <= '0;
            len_q          <= '0;
            widx_q         <= '0;
            lane_q         <= '0;
            pack_q         <= '0;
            weight_we_q    <= 1'b0;
            weight_addr_q  <= '0;
            weight_wdata_q <= '0;
            input_we_q     <= 1'b0;
            input_addr_q   <= '0;
            input_wdata_q  <= '0;
        end else begin
            sel_q          <= sel_d;
            base_q         <= base_d;
            len_q          <= len_d;
            widx_q         <= widx_d;
            lane_q         <= lane_d;
            pack_q         <= pack_d;
            weight_we_q    <= weight_we_d;
            weight_addr_q  <= weight_addr_d;
            weight_wdata_q <= weight_wdata_d;
            input_we_q     <= input_we_d;
            input_addr_q   <= input_addr_d;
            input_wdata_q  <= input_wdata_d;
        end
    end

    assign weight_we    = weight_we_q;
    assign weight_addr  = weight_addr_q;
    assign weight_wdata = weight_wdata_q;
    assign input_we     = input_we_q;
    assign input_addr   = input_addr_q;
    assign input_wdata  = input_wdata_q;

endmodule

// File: tb/tb_buffer_loader.sv
// Randomized self-checking bench for buffer_loader against a word-level
// model of the expected buffer writes.
module tb_buffer_loader;

    typedef logic [15:0] beat_q_t[$];

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_sel;
    logic [6:0]  cmd_base;
    logic [6:0]  cmd_len;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        abort;
    logic        weight_we;
    logic [6:0]  weight_addr;
    logic [79:0] weight_wdata;
    logic        input_we;
    logic [6:0]  input_addr;
    logic [15:0] input_wdata;
    logic        busy;
    logic        done;

    buffer_loader dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_sel      (cmd_sel),
        .cmd_base     (cmd_base),
        .cmd_len      (cmd_len),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .abort        (abort),
        .weight_we    (weight_we),
        .weight_addr  (weight_addr),
        .weight_wdata (weight_wdata),
        .input_we     (input_we),
        .input_addr   (input_addr),
        .input_wdata  (input_wdata),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int both_hi  = 0;

    logic [6:0]  wq_addr[$];
    logic [79:0] wq_data[$];
    int          wq_cyc[$];
    logic [6:0]  iq_addr[$];
    logic [15:0] iq_data[$];
    int          iq_cyc[$];
    int          done_cyc[$];
    int          acc_cyc[$];
    logic [6:0]  exp_addr[$];
    logic [79:0] exp_data[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Observe writes, done pulses and accepted beats mid-cycle
    always @(negedge clk) begin
        if (weight_we) begin
            wq_addr.push_back(weight_addr);
            wq_data.push_back(weight_wdata);
            wq_cyc.push_back(cyc);
        end
        if (input_we) begin
            iq_addr.push_back(input_addr);
            iq_data.push_back(input_wdata);
            iq_cyc.push_back(cyc);
        end
        if (weight_we && input_we) both_hi++;
        if (done) done_cyc.push_back(cyc);
        if (s_valid && s_ready) acc_cyc.push_back(cyc);
    end

    task automatic clear_mon();
        wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
        iq_addr.delete(); iq_data.delete(); iq_cyc.delete();
        done_cyc.delete(); acc_cyc.delete();
    endtask

    // Expected writes: word w goes to (base+w) mod 128; weight words hold beat k at bits 16k+
    function automatic void build_model(input bit sel, input int base, input int len,
                                        input beat_q_t beats);
        logic [79:0] word;
        exp_addr.delete();
        exp_data.delete();
        for (int w = 0; w <= len; w++) begin
            exp_addr.push_back(7'((base + w) % 128));
            if (sel) begin
                exp_data.push_back(80'(beats[w]));
            end else begin
                word = '0;
                for (int k = 0; k < 5; k++) word = word | (80'(beats[5*w+k]) << (16*k));
                exp_data.push_back(word);
            end
        end
    endfunction

    function automatic beat_q_t rand_beats(input int n);
        beat_q_t q;
        for (int i = 0; i < n; i++) q.push_back(16'($urandom));
        return q;
    endfunction

    task automatic do_cmd(input bit sel, input logic [6:0] base, input logic [6:0] len);
        int i;
        cmd_valid = 1'b1; cmd_sel = sel; cmd_base = base; cmd_len = len;
        i = 0;
        while (!cmd_ready && i < 20) begin @(posedge clk); #1; i++; end
        if (!cmd_ready) begin
            n_checks++; n_fail++;
            $display("FAIL cmd_handshake: cmd_ready stayed %b, required 1", cmd_ready);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_beats(input beat_q_t beats, input bit bubbles);
        int j;
        foreach (beats[b]) begin
            j = 0;
            while (bubbles && j < 8 && $urandom_range(0, 2) == 0) begin
                s_valid = 1'b0; s_data = 16'($urandom);
                @(posedge clk); #1; j++;
            end
            s_valid = 1'b1; s_data = beats[b];
            j = 0;
            while (!s_ready && j < 20) begin @(posedge clk); #1; j++; end
            if (!s_ready) begin
                n_checks++; n_fail++;
                $display("FAIL beat_handshake: s_ready stayed %b, required 1", s_ready);
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_done();
        int i = 0;
        while (done_cyc.size() == 0 && i < 100) begin @(negedge clk); i++; end
        if (done_cyc.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL done_timeout: no done pulse, required one");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_sel = 1'b0; cmd_base = '0; cmd_len = '0;
        s_valid = 1'b0; s_data = '0; abort = 1'b0;
        #12;
        n_checks++;
        if (cmd_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_cmd_ready: got %b, required 0", cmd_ready);
        end
        n_checks++;
        if ({s_ready, weight_we, weight_addr, weight_wdata, input_we, input_addr,
             input_wdata, busy, done} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got nonzero output, required all 0");
        end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: cmd_ready=%b busy=%b s_ready=%b, required 1 0 0",
                     cmd_ready, busy, s_ready);
        end
    endtask

    task automatic test_input_load();
        beat_q_t beats;
        beats = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};
        clear_mon();
        build_model(1'b1, 'h10, 3, beats);
        @(posedge clk); #1;
        do_cmd(1'b1, 7'h10, 7'd3);
        n_checks++;
        if (s_ready !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL input_load_ready: s_ready=%b busy=%b, required 1 1", s_ready, busy);
        end
        send_beats(beats, 1'b0);
        wait_done();
        n_checks++;
        if (s_ready !== 1'b0) begin
            n_fail++; $display("FAIL input_load_sready_done: got %b, required 0", s_ready);
        end
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL input_load_cmd_ready: got %b, required 1", cmd_ready);
        end
        n_checks++;
        if (iq_addr.size() !== 4 || wq_addr.size() !== 0 || done_cyc.size() !== 1) begin
            n_fail++;
            $display("FAIL input_load_counts: input=%0d weight=%0d done=%0d, required 4 0 1",
                     iq_addr.size(), wq_addr.size(), done_cyc.size());
        end
        for (int k = 0; k < iq_addr.size() && k < 4; k++) begin
            n_checks++;
            if (iq_addr[k] !== exp_addr[k] || 80'(iq_data[k]) !== exp_data[k] ||
                iq_cyc[k] !== iq_cyc[0] + k) begin
                n_fail++;
                $display("FAIL input_load_word%0d: addr=%h data=%h cyc=%0d, required %h %h %0d",
                         k, iq_addr[k], iq_data[k], iq_cyc[k], exp_addr[k], exp_data[k][15:0],
                         iq_cyc[0] + k);
            end
        end
        if (iq_cyc.size() == 4 && done_cyc.size() == 1 && acc_cyc.size() == 4) begin
            n_checks++;
            if (done_cyc[0] !== iq_cyc[3] || iq_cyc[3] !== acc_cyc[3] + 1) begin
                n_fail++;
                $display("FAIL input_load_timing: done=%0d last_we=%0d last_acc=%0d",
                         done_cyc[0], iq_cyc[3], acc_cyc[3]);
            end
        end
    endtask

    task automatic test_weight_load();
        beat_q_t beats;
        beats = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
        clear_mon();
        @(posedge clk); #1;
        do_cmd(1'b0, 7'd5, 7'd0);
        send_beats(beats, 1'b0);
        wait_done();
        @(negedge clk);
        n_checks++;
        if (wq_addr.size() !== 1 || iq_addr.size() !== 0 || acc_cyc.size() !== 5) begin
            n_fail++;
            $display("FAIL weight_load_counts: weight=%0d input=%0d beats=%0d, required 1 0 5",
                     wq_addr.size(), iq_addr.size(), acc_cyc.size());
        end
        if (wq_addr.size() == 1 && acc_cyc.size() == 5 && done_cyc.size() == 1) begin
            n_checks++;
            if (wq_addr[0] !== 7'd5 || wq_data[0] !== 80'h5555_4444_3333_2222_1111) begin
                n_fail++;
                $display("FAIL weight_load_word: addr=%h data=%h, required 05 55554444333322221111",
                         wq_addr[0], wq_data[0]);
            end
            n_checks++;
            if (wq_cyc[0] !== acc_cyc[4] + 1 || done_cyc[0] !== wq_cyc[0]) begin
                n_fail++;
                $display("FAIL weight_load_timing: we=%0d done=%0d last_acc=%0d",
                         wq_cyc[0], done_cyc[0], acc_cyc[4]);
            end
        end
    endtask

    task automatic test_wrap();
        beat_q_t beats;
        beats = rand_beats(4);
        clear_mon();
        build_model(1'b1, 'h7E, 3, beats);
        @(posedge clk); #1;
        do_cmd(1'b1, 7'h7E, 7'd3);
        send_beats(beats, 1'b0);
        wait_done();
        @(negedge clk);
        n_checks++;
        if (iq_addr.size() !== 4) begin
            n_fail++; $display("FAIL wrap_count: got %0d writes, required 4", iq_addr.size());
        end
        for (int k = 0; k < iq_addr.size() && k < 4; k++) begin
            n_checks++;
            if (iq_addr[k] !== exp_addr[k] || 80'(iq_data[k]) !== exp_data[k]) begin
                n_fail++;
                $display("FAIL wrap_word%0d: addr=%h data=%h, required %h %h",
                         k, iq_addr[k], iq_data[k], exp_addr[k], exp_data[k][15:0]);
            end
        end
    endtask

    task automatic test_bubbles();
        beat_q_t     beats;
        logic [6:0]  base;
        logic [6:0]  ref_addr[$];
        logic [79:0] ref_data[$];
        beats = rand_beats(10);
        base  = 7'($urandom);
        build_model(1'b0, int'(base), 1, beats);
        clear_mon();
        @(posedge clk); #1;
        do_cmd(1'b0, base, 7'd1);
        send_beats(beats, 1'b0);
        wait_done();
        @(negedge clk);
        ref_addr = wq_addr;
        ref_data = wq_data;

        clear_mon();
        @(posedge clk); #1;
        do_cmd(1'b0, base, 7'd1);
        send_beats(beats, 1'b1);
        s_valid = 1'b1; s_data = 16'($urandom);
        repeat (4) begin @(posedge clk); #1; end
        s_valid = 1'b0;
        wait_done();
        @(negedge clk);
        n_checks++;
        if (acc_cyc.size() !== 10 || wq_addr.size() !== 2 || done_cyc.size() !== 1) begin
            n_fail++;
            $display("FAIL bubbles_counts: beats=%0d writes=%0d done=%0d, required 10 2 1",
                     acc_cyc.size(), wq_addr.size(), done_cyc.size());
        end
        for (int k = 0; k < wq_addr.size() && k < 2; k++) begin
            n_checks++;
            if (wq_addr[k] !== exp_addr[k] || wq_data[k] !== exp_data[k] ||
                k >= ref_addr.size() || wq_addr[k] !== ref_addr[k] || wq_data[k] !== ref_data[k]) begin
                n_fail++;
                $display("FAIL bubbles_word%0d: addr=%h data=%h, required %h %h",
                         k, wq_addr[k], wq_data[k], exp_addr[k], exp_data[k]);
            end
            if (acc_cyc.size() == 10) begin
                n_checks++;
                if (wq_cyc[k] !== acc_cyc[5*k+4] + 1) begin
                    n_fail++;
                    $display("FAIL bubbles_strobe%0d: cyc=%0d, required %0d",
                             k, wq_cyc[k], acc_cyc[5*k+4] + 1);
                end
            end
        end
    endtask

    task automatic test_abort();
        beat_q_t    beats;
        logic [6:0] base;
        clear_mon();
        @(posedge clk); #1;
        do_cmd(1'b0, 7'($urandom), 7'd0);
        beats = rand_beats(3);
        send_beats(beats, 1'b0);
        abort = 1'b1; s_valid = 1'b1; s_data = 16'($urandom);
        #1;
        n_checks++;
        if (s_ready !== 1'b0) begin
            n_fail++; $display("FAIL abort_sready: got %b, required 0", s_ready);
        end
        @(posedge clk); #1;
        abort = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_idle: cmd_ready=%b busy=%b, required 1 0", cmd_ready, busy);
        end
        repeat (6) @(negedge clk);
        n_checks++;
        if (wq_addr.size() !== 0 || done_cyc.size() !== 0 || acc_cyc.size() !== 3) begin
            n_fail++;
            $display("FAIL abort_quiet: writes=%0d done=%0d beats=%0d, required 0 0 3",
                     wq_addr.size(), done_cyc.size(), acc_cyc.size());
        end

        clear_mon();
        base  = 7'($urandom);
        beats = rand_beats(5);
        build_model(1'b0, int'(base), 0, beats);
        @(posedge clk); #1;
        do_cmd(1'b0, base, 7'd0);
        send_beats(beats, 1'b0);
        wait_done();
        @(negedge clk);
        n_checks++;
        if (wq_addr.size() !== 1) begin
            n_fail++; $display("FAIL abort_reload_count: got %0d writes, required 1", wq_addr.size());
        end else begin
            n_checks++;
            if (wq_addr[0] !== exp_addr[0] || wq_data[0] !== exp_data[0]) begin
                n_fail++;
                $display("FAIL abort_reload_word: addr=%h data=%h, required %h %h",
                         wq_addr[0], wq_data[0], exp_addr[0], exp_data[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        beat_q_t beats;
        clear_mon();
        beats = rand_beats(2);
        @(posedge clk); #1;
        do_cmd(1'b1, 7'($urandom), 7'd3);
        send_beats(beats, 1'b0);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({cmd_ready, s_ready, weight_we, weight_addr, weight_wdata, input_we, input_addr,
             input_wdata, busy, done} !== '0) begin
            n_fail++; $display("FAIL reset_mid_outputs: got nonzero output, required all 0");
        end
        @(posedge clk); #1;
        rst = 1'b0;
        s_valid = 1'b1; s_data = 16'($urandom);
        repeat (3) begin @(posedge clk); #1; end
        s_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_idle: cmd_ready=%b, required 1", cmd_ready);
        end
        n_checks++;
        if (iq_addr.size() !== 2 || done_cyc.size() !== 0 || acc_cyc.size() !== 2) begin
            n_fail++;
            $display("FAIL reset_mid_counts: writes=%0d done=%0d beats=%0d, required 2 0 2",
                     iq_addr.size(), done_cyc.size(), acc_cyc.size());
        end
    endtask

    task automatic test_one_hot();
        n_checks++;
        if (both_hi !== 0) begin
            n_fail++; $display("FAIL strobe_one_hot: both strobes high in %0d cycles, required 0", both_hi);
        end
    endtask

    initial begin
        test_reset();
        test_input_load();
        test_weight_load();
        test_wrap();
        test_bubbles();
        test_abort();
        test_reset_mid();
        test_one_hot();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
